// File: rtl/text_pixel_gen.sv
// text_pixel_gen: text-mode pixel generator fetching char and glyph words per pixel over a
// variable-latency memory handshake; colours the staged pixel on the next pix_req.
module text_pixel_gen #(
    parameter int H_OFFSET    = 48,
    parameter int V_OFFSET    = 33,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int GLYPH_H     = 8,
    parameter int TEXT_STRIDE = 128,
    parameter int GLYPH_BASE  = 'h2000,
    parameter int ADDR_W      = 14,
    parameter int BLINK_LOG2  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_req,
    input  logic [9:0]        next_col,
    input  logic [9:0]        next_row,
    input  logic [1:0]        mode,
    input  logic [7:0]        sw_color,
    input  logic [6:0]        cursor_col,
    input  logic [5:0]        cursor_row,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [15:0]       mem_data,
    output logic [7:0]        next_color,
    output logic              ready,
    output logic              underrun
);
    typedef enum logic [2:0] {IDLE, STAGE, C_REQ, C_WAIT, G_REQ, G_WAIT, READY} state_t;
    localparam int GL_LOG2 = (GLYPH_H == 16) ? 4 : 3;
    localparam logic [9:0] HA = 10'(H_ACTIVE);
    localparam logic [9:0] VA = 10'(V_ACTIVE);

    state_t state, state_nx;
    logic [9:0] lc, lr, tr;
    logic [6:0] tc;
    logic [3:0] gl;
    logic [1:0] smode;
    logic [15:0] chr, gly;
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic [30:0] lfsr;
    logic [2:0] stale;
    logic in_frame, fresh, hit, abandon, lit, cursor;
    logic [7:0] attr, glyph_byte, text_color, pix_color;
    logic [ADDR_W-1:0] char_addr, glyph_addr;

    assign in_frame   = lc < HA && lr < VA;
    assign tc         = lc[9:3];
    assign tr         = lr >> GL_LOG2;
    assign gl         = lr[3:0] & 4'(GLYPH_H - 1);
    assign char_addr  = ADDR_W'(tr) * ADDR_W'(TEXT_STRIDE) + ADDR_W'(tc);
    assign glyph_addr = ADDR_W'(GLYPH_BASE) + ADDR_W'(chr[7:0]) * ADDR_W'(GLYPH_H / 2) + ADDR_W'(gl[3:1]);
    assign mem_rd     = state == C_REQ || state == G_REQ;
    assign mem_addr   = state == C_REQ ? char_addr : state == G_REQ ? glyph_addr : '0;
    assign ready      = state == READY;

    // Responses owed to abandoned fetches are counted and dropped as they return.
    assign hit     = mem_valid && stale != 0;
    assign fresh   = mem_valid && stale == 0 && (state == C_WAIT || state == G_WAIT);
    assign abandon = pix_req && (state == C_REQ || state == C_WAIT || state == G_REQ || state == G_WAIT) && !fresh;

    assign attr       = chr[15:8];
    assign glyph_byte = gl[0] ? gly[7:0] : gly[15:8];
    assign lit        = glyph_byte[~lc[2:0]];
    assign text_color = smode == 2'd2 ? (lit ? attr : (attr != 0 ? {attr[4:2], 5'b0} : 8'h00))
                                      : (lit ? 8'hFF : 8'h00);
    assign cursor     = tc == cursor_col && tr == {4'b0, cursor_row} && frame_cnt[BLINK_LOG2-1];
    assign pix_color  = !in_frame ? 8'h00 :
                        smode == 2'd0 ? ((lc[6] ^ lr[6]) ? 8'h00 : sw_color) :
                        smode == 2'd1 ? lfsr[7:0] :
                        cursor ? ~text_color : text_color;

    always_comb begin
        state_nx = state;
        case (state)
            STAGE:   state_nx = (in_frame && mode[1]) ? C_REQ : READY;
            C_REQ:   state_nx = C_WAIT;
            C_WAIT:  state_nx = fresh ? G_REQ : C_WAIT;
            G_REQ:   state_nx = G_WAIT;
            G_WAIT:  state_nx = fresh ? READY : G_WAIT;
            default: state_nx = state;
        endcase
        if (pix_req) state_nx = STAGE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lc         <= '0;
            lr         <= '0;
            smode      <= '0;
            chr        <= '0;
            gly        <= '0;
            frame_cnt  <= '0;
            lfsr       <= 31'd733;
            stale      <= '0;
            next_color <= '0;
            underrun   <= 1'b0;
        end else begin
            state <= state_nx;
            lfsr  <= {lfsr[28:0], lfsr[30] ^ lfsr[28], lfsr[29] ^ lfsr[27]};
            stale <= stale + 3'(abandon) - 3'(hit);
            if (state == STAGE) smode <= mode;
            if (fresh && state == C_WAIT) chr <= mem_data;
            if (fresh && state == G_WAIT) gly <= mem_data;
            if (pix_req) begin
                lc         <= next_col - 10'(H_OFFSET);
                lr         <= next_row - 10'(V_OFFSET);
                next_color <= ready ? pix_color : 8'h00;
                underrun   <= underrun | !ready;
                if (next_col == 0 && next_row == 0) frame_cnt <= frame_cnt + BLINK_LOG2'(1);
            end
        end
    end
endmodule

// File: tb/tb_text_pixel_gen.sv
// tb_text_pixel_gen: directed stimulus with a colour scoreboard, a latency-programmable
// memory responder and inline checks of handshake, underrun, cursor and reset behaviour.
module tb_text_pixel_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_req = 1'b0;
    logic [9:0]  next_col = '0, next_row = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  sw_color = '0;
    logic [6:0]  cursor_col = 7'd127;
    logic [5:0]  cursor_row = 6'd63;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic [7:0]  next_color;
    logic        ready, underrun;

    text_pixel_gen #(.BLINK_LOG2(1)) dut (
        .clk(clk), .rst_n(rst_n), .pix_req(pix_req), .next_col(next_col), .next_row(next_row),
        .mode(mode), .sw_color(sw_color), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .next_color(next_color), .ready(ready), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic req_d = 1'b0;
    int rd_total = 0, rd_base = 0;

    typedef struct {int due; logic [15:0] d;} rsp_t;
    rsp_t rsp_q[$];
    logic [15:0] mem [0:16383];
    int lat = 1, cyc = 0;
    logic [30:0] lf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory responder: each read is answered lat cycles after it is seen.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            rsp_q.delete();
            mem_valid <= 1'b0;
        end else begin
            if (mem_rd) begin
                rsp_q.push_back('{cyc + lat, mem[mem_addr]});
                rd_total <= rd_total + 1;
            end
            if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
                mem_valid <= 1'b1;
                mem_data  <= rsp_q[0].d;
                void'(rsp_q.pop_front());
            end else mem_valid <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) lf <= 31'd733;
        else lf <= {lf[28:0], lf[30] ^ lf[28], lf[29] ^ lf[27]};

    always @(posedge clk) req_d <= pix_req;

    always @(negedge clk)
        if (req_d) begin
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else chk("next_color", next_color, exp_q.pop_front());
        end

    // Called at a negedge: presents the staged pixel (expect exp) and stages (c,r).
    task automatic req(input int c, input int r, input logic [7:0] exp);
        exp_q.push_back(exp);
        next_col = 10'(c);
        next_row = 10'(r);
        pix_req = 1'b1;
        rd_base = rd_total;
        @(negedge clk);
        pix_req = 1'b0;
    endtask

    task automatic wait_ready(input int exp_rd);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", ready, 1);
        if (exp_rd >= 0) chk("mem_rd_count", rd_total - rd_base, exp_rd);
    endtask

    task automatic oob_check;
        chk("oob_stage_ready", ready, 0);
        @(negedge clk);
        chk("oob_ready_next", ready, 1);
        chk("oob_no_rd", rd_total - rd_base, 0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        mem[0]          = 16'h0041;
        mem[1]          = 16'h0042;
        mem[14'h2104]   = 16'h8001;
        repeat (3) @(negedge clk);
        chk("rst_color", next_color, 0);
        chk("rst_ready", ready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_mem_rd", mem_rd, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 2'd0; sw_color = 8'h1C;
        req(48, 33, 8'h00);
        chk("underrun_idle", underrun, 1);
        wait_ready(0);
        req(112, 33, 8'h1C);
        wait_ready(0);

        mode = 2'd3;
        req(48, 33, 8'h00);
        wait_ready(2);
        req(49, 33, 8'hFF);
        wait_ready(2);
        req(55, 34, 8'h00);
        wait_ready(2);

        mode = 2'd2; mem[0] = 16'hE441; lat = 3;
        req(48, 33, 8'hFF);
        wait_ready(2);
        req(49, 33, 8'hE4);
        wait_ready(2);
        req(0, 0, 8'h20);
        oob_check();
        req(700, 600, 8'h00);
        oob_check();

        // Abandon a fetch in C_WAIT; its late response must not reach the next pixel.
        mode = 2'd3;
        req(48, 33, 8'h00);
        @(negedge clk);
        @(negedge clk);
        lat = 6;
        req(56, 33, 8'h00);
        chk("underrun_sticky", underrun, 1);
        wait_ready(2);
        req(48, 33, 8'h00);
        wait_ready(2);
        chk("underrun_stays", underrun, 1);
        req(48, 33, 8'hFF);
        for (int n = 0; n < 100 && rd_total - rd_base < 2; n++) @(negedge clk);
        chk("reached_g_wait", rd_total - rd_base, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_color", next_color, 0);
        chk("arst_ready", ready, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_mem_rd", mem_rd, 0);
        chk("arst_mem_addr", mem_addr, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 2'd3; lat = 1; cursor_col = 7'd0; cursor_row = 6'd0;
        req(48, 33, 8'h00);
        wait_ready(2);
        req(0, 0, 8'hFF);
        wait_ready(0);
        req(48, 33, 8'h00);
        wait_ready(2);
        req(0, 0, 8'h00);
        wait_ready(0);
        req(48, 33, 8'h00);
        wait_ready(2);
        req(0, 0, 8'hFF);
        wait_ready(0);
        mode = 2'd1;
        req(48, 33, 8'h00);
        wait_ready(0);
        req(0, 0, lf[7:0]);
        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
